// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: drives PC/stage-register enables and flushes from dmem wait,
// branch redirect, load-use and fetch-wait conditions, and keeps stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int TMO_W            = 8,
  parameter int CNT_W            = 16
) (
  input  logic             clk_I,
  input  logic             reset_I,
  input  logic [4:0]       idRs1Addr_I,
  input  logic [4:0]       idRs2Addr_I,
  input  logic             idUsesRs1_I,
  input  logic             idUsesRs2_I,
  input  logic [4:0]       exRdAddr_I,
  input  logic             exMemRead_I,
  input  logic             memBranchTaken_I,
  input  logic             memReq_I,
  input  logic             dmemReady_I,
  input  logic             imemReady_I,
  output logic             pcEn_O,
  output logic             pcRedirect_O,
  output logic             ifidEn_O,
  output logic             ifidFlush_O,
  output logic             idexEn_O,
  output logic             idexFlush_O,
  output logic             exmemEn_O,
  output logic             exmemFlush_O,
  output logic             memwbEn_O,
  output logic             memTimeout_O,
  output logic [CNT_W-1:0] stallCount_O,
  output logic [CNT_W-1:0] flushCount_O
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

  localparam logic [1:0]       BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_HIT  = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d, saved_q, saved_d, eff_state;
  logic [1:0]       bub_q, bub_d, bub_nxt;
  logic [TMO_W-1:0] wcnt_q, wcnt_d;
  logic             to_q, to_hit;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             hz, dwait;

  assign hz = exMemRead_I && (exRdAddr_I != 5'd0) &&
              ((idUsesRs1_I && (idRs1Addr_I == exRdAddr_I)) ||
               (idUsesRs2_I && (idRs2Addr_I == exRdAddr_I)));
  assign dwait = memReq_I && !dmemReady_I;

  // Leaving MEM_WAIT is decided as if we were still in the state that was interrupted.
  assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;
  assign bub_nxt   = (eff_state == LOAD_STALL) ? (bub_q - 2'd1) : BUB_INIT;

  always_comb begin
    pcEn_O       = 1'b0;
    pcRedirect_O = 1'b0;
    ifidEn_O     = 1'b0;
    ifidFlush_O  = 1'b0;
    idexEn_O     = 1'b0;
    idexFlush_O  = 1'b0;
    exmemEn_O    = 1'b0;
    exmemFlush_O = 1'b0;
    memwbEn_O    = 1'b0;
    state_d      = state_q;
    saved_d      = saved_q;
    bub_d        = bub_q;
    if (reset_I) begin
      state_d = RUN;
    end else if (dwait) begin
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT) saved_d = state_q;
    end else if (memBranchTaken_I) begin
      {pcEn_O, ifidEn_O, idexEn_O, exmemEn_O, memwbEn_O} = '1;
      {pcRedirect_O, ifidFlush_O, idexFlush_O, exmemFlush_O} = '1;
      state_d = RUN;
      bub_d   = 2'd0;
    end else if (eff_state == LOAD_STALL || (eff_state == RUN && hz)) begin
      {idexEn_O, idexFlush_O, exmemEn_O, memwbEn_O} = '1;
      bub_d   = bub_nxt;
      state_d = (bub_nxt == 2'd0) ? RUN : LOAD_STALL;
    end else if (!imemReady_I) begin
      {idexEn_O, idexFlush_O, exmemEn_O, memwbEn_O} = '1;
      state_d = RUN;
    end else begin
      {pcEn_O, ifidEn_O, idexEn_O, exmemEn_O, memwbEn_O} = '1;
      state_d = RUN;
    end
  end

  // Timeout shows on the very wait cycle that reaches the limit, then latches.
  assign to_hit       = !reset_I && dwait && (wcnt_q >= TMO_HIT);
  assign memTimeout_O = to_q || to_hit;
  assign wcnt_d       = !dwait ? '0 : (wcnt_q == TMO_LIM) ? wcnt_q : wcnt_q + 1'b1;

  always_ff @(posedge clk_I or posedge reset_I) begin
    if (reset_I) begin
      state_q <= RUN;
      saved_q <= RUN;
      bub_q   <= 2'd0;
      wcnt_q  <= '0;
      to_q    <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      bub_q   <= bub_d;
      wcnt_q  <= wcnt_d;
      to_q    <= to_q || to_hit;
      if (!pcEn_O && stall_q != '1)      stall_q <= stall_q + 1'b1;
      if (pcRedirect_O && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign stallCount_O = stall_q;
  assign flushCount_O = flush_q;

endmodule
